// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM sender: FSM state encoding, SPI mode and byte geometry.
package spi_ram_pkg;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t   SPI_MODE      = '{cpol: 1'b0, cpha: 1'b0};
   localparam int unsigned BITS_PER_BYTE = 8;

   // ST_GAP is only reachable when the inter-byte gap option is built in.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_SETUP = 3'd3,
      ST_SHIFT = 3'd4,
      ST_HOLD  = 3'd5,
      ST_DONE  = 3'd6,
      ST_GAP   = 3'd7
   } state_e;

endpackage

// File: rtl/spi_ram_sclk_gen.sv
// SCLK half-period timer: counts CLKDIV cycles while enabled, toggles SCLK when allowed,
// and flags the cycle before each SCLK rise/fall.
module spi_ram_sclk_gen
   import spi_ram_pkg::*;
#(
   parameter int unsigned CLKDIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_toggle,
   output logic o_sclk,
   output logic o_tick_c,
   output logic o_rise_c,
   output logic o_fall_c
);

   localparam int unsigned CW      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKDIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;

   assign o_tick_c = i_en & (cnt_q == CNT_MAX);
   assign o_rise_c = o_tick_c & i_toggle & (sclk_q == SPI_MODE.cpol);
   assign o_fall_c = o_tick_c & i_toggle & (sclk_q != SPI_MODE.cpol);
   assign o_sclk   = sclk_q;

   // Disabled: counter parked at zero and SCLK at its idle level.
   always_comb begin
      cnt_d  = '0;
      sclk_d = SPI_MODE.cpol;
      if (i_en) begin
         cnt_d  = o_tick_c ? '0 : cnt_q + CW'(1);
         sclk_d = (o_tick_c & i_toggle) ? ~sclk_q : sclk_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q  <= '0;
         sclk_q <= SPI_MODE.cpol;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_ram_sender.sv
// SPI mode-0 master that streams i_len bytes from a source SRAM in one CS frame, MSB first.
// Build option SPI_RAM_SENDER_GAP_EN inserts 2*CLKDIV idle SCLK-low cycles between bytes.
module spi_ram_sender
   import spi_ram_pkg::*;
#(
   parameter int unsigned AW     = 10,
   parameter int unsigned CLKDIV = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [AW:0]   i_len,
   output logic          o_busy,
   output logic          o_done,
   output logic [AW-1:0] o_sram_raddr,
   output logic          o_sram_ren,
   input  logic [7:0]    i_sram_rdata,
   output logic          o_sclk,
   output logic          o_cs_n,
   output logic          o_mosi
);

   localparam int unsigned BW      = $clog2(BITS_PER_BYTE + 1);
   localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW:0]     rem_q, rem_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic            first_q, first_d;
   logic            cs_n_q, cs_n_d;
   logic            ren_q, ren_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

`ifdef SPI_RAM_SENDER_GAP_EN
   localparam int unsigned GAP_LEN = 2 * CLKDIV;
   localparam int unsigned GW      = $clog2(GAP_LEN);
   logic [GW-1:0]   gap_q, gap_d;
`endif

   logic gen_en_c, gen_toggle_c, tick_c, rise_c, fall_c;

   assign gen_en_c     = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
   assign gen_toggle_c = (state_q == ST_SHIFT);

   spi_ram_sclk_gen #(
      .CLKDIV (CLKDIV)
   ) u_sclk_gen (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (gen_en_c),
      .i_toggle (gen_toggle_c),
      .o_sclk   (o_sclk),
      .o_tick_c (tick_c),
      .o_rise_c (rise_c),
      .o_fall_c (fall_c)
   );

   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_sram_raddr = addr_q;
   assign o_sram_ren   = ren_q;
   assign o_cs_n       = cs_n_q;
   assign o_mosi       = shreg_q[7];

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      first_d = first_q;
      cs_n_d  = cs_n_q;
      done_d  = 1'b0;
`ifdef SPI_RAM_SENDER_GAP_EN
      gap_d   = gap_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (i_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
                  addr_d  = '0;
                  rem_d   = (i_len > MAX_LEN) ? MAX_LEN : i_len;
                  first_d = 1'b1;
               end
            end
         end
         ST_FETCH: state_d = ST_LATCH;
         ST_LATCH: begin
            shreg_d = i_sram_rdata;
            bit_d   = '0;
            first_d = 1'b0;
            state_d = first_q ? ST_SETUP : ST_SHIFT;
         end
         ST_SETUP: begin
            if (tick_c) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (rise_c) bit_d = bit_q + BW'(1);
            if (fall_c) begin
               shreg_d = {shreg_q[6:0], 1'b0};
               if (bit_q == BW'(BITS_PER_BYTE)) begin
                  rem_d = rem_q - (AW+1)'(1);
                  if (rem_q == (AW+1)'(1)) begin
                     state_d = ST_HOLD;
                     shreg_d = '0;
                  end else begin
                     // Address only advances when another byte follows, so a full-memory send never wraps.
                     addr_d = addr_q + AW'(1);
`ifdef SPI_RAM_SENDER_GAP_EN
                     state_d = ST_GAP;
                     gap_d   = '0;
`else
                     state_d = ST_FETCH;
`endif
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick_c) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_GAP: begin
`ifdef SPI_RAM_SENDER_GAP_EN
            if (gap_q == GW'(GAP_LEN - 1)) state_d = ST_FETCH;
            else                           gap_d   = gap_q + GW'(1);
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      // CS drops entering SETUP and only rises leaving the frame, so it cannot glitch between bytes.
      if (state_d == ST_SETUP)                          cs_n_d = 1'b0;
      if ((state_d == ST_DONE) || (state_d == ST_IDLE)) cs_n_d = 1'b1;
      if (state_d == ST_DONE)                           done_d = 1'b1;
      ren_d  = (state_d == ST_FETCH);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         shreg_q <= '0;
         bit_q   <= '0;
         first_q <= 1'b0;
         cs_n_q  <= 1'b1;
         ren_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SPI_RAM_SENDER_GAP_EN
         gap_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         first_q <= first_d;
         cs_n_q  <= cs_n_d;
         ren_q   <= ren_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SPI_RAM_SENDER_GAP_EN
         gap_q   <= gap_d;
`endif
      end
   end

endmodule

// File: doc/spi_ram_sender.md
SPI_RAM_SENDER -- requirements
Module: spi_ram_sender

Interface
REQ-001 SHALL have parameter AW, default 10: SRAM byte address width.
REQ-002 SHALL have parameter CLKDIV, default 2: SCLK half-period in i_clk cycles, legal range 1 or more.
REQ-003 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_start  in  1  one-cycle request to send an image.
REQ-006 SHALL have port i_len  in  AW+1  byte count, sampled on accepted i_start.
REQ-007 SHALL have port o_busy  out  1  transfer in progress.
REQ-008 SHALL have port o_done  out  1  one-cycle pulse at transfer end.
REQ-009 SHALL have port o_sram_raddr  out  AW  source SRAM read address.
REQ-010 SHALL have port o_sram_ren  out  1  source SRAM read enable.
REQ-011 SHALL have port i_sram_rdata  in  8  read data, valid the cycle after o_sram_ren.
REQ-012 SHALL have port o_sclk, o_cs_n, o_mosi  out  1 each  SPI master lines, matching the loader's i_sclk/i_cs_n/i_mosi.

Function
REQ-013 SHALL act as SPI master, mode 0: SCLK idles low; MOSI changes only while SCLK is low; the receiver samples on SCLK rising edge; MSB first.
REQ-014 SHALL accept i_start only in IDLE; i_start while busy SHALL be ignored.
REQ-015 SHALL, on accepted i_start with i_len=0, stay in IDLE with o_cs_n high and pulse o_done on the next cycle.
REQ-016 SHALL use FSM states IDLE, FETCH, LATCH, SETUP, SHIFT, HOLD, DONE.
REQ-017 IDLE->FETCH on accepted i_start with i_len>0: address counter cleared to 0; remaining count loaded from i_len.
REQ-018 FETCH: SHALL assert o_sram_ren for exactly one cycle at the current address, then go to LATCH.
REQ-019 LATCH: SHALL load i_sram_rdata into the 8-bit shift register and drive its bit 7 onto o_mosi. Go to SETUP for the first byte; go to SHIFT otherwise.
REQ-020 SETUP: SHALL drive o_cs_n low for CLKDIV cycles with SCLK low before the first rising edge.
REQ-021 SHIFT: each bit SHALL take CLKDIV cycles SCLK low, then CLKDIV cycles SCLK high; the shift register SHALL shift left on the SCLK falling edge; a byte is 16*CLKDIV cycles.
REQ-022 After bit 0, SHALL decrement the remaining count and increment the address. If the count is nonzero, go to FETCH with o_cs_n held low and SCLK low. If the count is zero, go to HOLD.
REQ-023 HOLD: SHALL keep SCLK low and o_cs_n low for CLKDIV cycles, then raise o_cs_n and go to DONE.
REQ-024 DONE: SHALL pulse o_done one cycle, then return to IDLE.
REQ-025 o_busy SHALL be high in every state except IDLE.
REQ-026 The address SHALL cover 0 to i_len-1 contiguously. i_len = 2**AW SHALL send the whole memory without wrap. Values above 2**AW SHALL be clamped to 2**AW.
REQ-027 o_cs_n SHALL stay low, without glitch, for the whole multi-byte frame.

Reset
REQ-028 On i_rst, on the next edge, SHALL force: state IDLE, o_cs_n=1, o_sclk=0, o_mosi=0, o_sram_ren=0, o_sram_raddr=0, o_busy=0, o_done=0, counters cleared.
REQ-029 Reset mid-transfer SHALL abort with no o_done pulse; the partial byte is discarded by the receiver via o_cs_n rising.

Configuration
REQ-030 With SPI_RAM_SENDER_GAP_EN defined, SHALL insert 2*CLKDIV idle cycles between bytes, with SCLK low and o_cs_n low, before each FETCH after the first.
REQ-031 Without SPI_RAM_SENDER_GAP_EN, SHALL insert no gap; only the 2-cycle FETCH/LATCH bubble separates bytes.

Structure
REQ-032 Shared package spi_ram_pkg SHALL hold the state enum, SPI mode constant (CPOL=0, CPHA=0) and the bits-per-byte constant 8.
REQ-033 SHALL contain one sub-module, spi_ram_sclk_gen: a CLKDIV counter emitting rise/fall strobes, enabled only in SETUP/SHIFT/HOLD.

Verification
REQ-034 CLKDIV=1, SRAM[0..2]=A5,3C,FF, i_len=3 -> receiver bench captures A5,3C,FF; o_cs_n low once; 24 rising SCLK edges; one o_done pulse.
REQ-035 i_len=0 -> o_done pulse one cycle after i_start; o_cs_n never low; o_sram_ren never high.
REQ-036 AW=4, i_len=16, SRAM[i]=i -> bytes 00..0F received; last o_sram_raddr=0xF; no address wrap.
REQ-037 i_rst asserted after 4 SCLK rises of byte 1 -> next cycle o_cs_n=1, o_sclk=0, o_busy=0; no o_done; a new i_start then sends from address 0.
REQ-038 i_start pulsed again mid-transfer -> ignored; byte count and data unchanged.
REQ-039 CLKDIV=3 with SPI_RAM_SENDER_GAP_EN, i_len=2 -> SCLK high 3 cycles, low 3 cycles; 6 idle cycles between bytes; end-to-end loopback through spi_ram_loader into a second RAM matches the source.
